// File: rtl/text_memory_fetch_bus.sv
// text_memory_fetch_bus: instruction-fetch bus between the fetch stage and a
// synchronous text RAM. It adds a valid/ready request/response handshake and
// in-band address faults, and absorbs back-pressure in a small response FIFO.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   flush               discard every in-flight and buffered fetch
//   req_valid/ready     request handshake, req_address is a byte address
//   resp_valid/ready    response handshake
//   resp_data           instruction word (0 on fault)
//   resp_address        address of the originating request
//   resp_fault          00 ok, 01 misaligned, 10 out of range
//   mem_address/read    word address and read enable to the text RAM
//   mem_read_data       RAM data, READ_LATENCY edges after the read edge
module text_memory_fetch_bus #(
  parameter logic [31:0] TEXT_BEGIN   = 32'h0040_0000,
  parameter int unsigned TEXT_BITS    = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  input  logic [31:0]          req_address,
  output logic                 req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [31:0]          resp_address,
  output logic [1:0]           resp_fault,
  output logic [TEXT_BITS-3:0] mem_address,
  output logic                 mem_read,
  input  logic [31:0]          mem_read_data
);

  localparam int unsigned DEPTH = READ_LATENCY + 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] TEXT_END = TEXT_BEGIN + 32'((64'd1 << TEXT_BITS) - 64'd1);

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  logic [CNT_W-1:0] count;
  logic             accept;
  logic             pop;
  logic             push;
  logic [1:0]       req_fault;
  logic [31:0]      push_data;

  // Tracking pipeline, aligned with the RAM read latency
  logic        pipe_valid [READ_LATENCY];
  logic [1:0]  pipe_fault [READ_LATENCY];
  logic [31:0] pipe_addr  [READ_LATENCY];

  // Response FIFO as a shift queue: entry 0 is always the head, so the
  // response outputs come straight from registers.
  logic        fifo_valid   [DEPTH];
  logic [31:0] fifo_data    [DEPTH];
  logic [31:0] fifo_addr    [DEPTH];
  logic [1:0]  fifo_fault   [DEPTH];
  logic        fifo_valid_n [DEPTH];
  logic [31:0] fifo_data_n  [DEPTH];
  logic [31:0] fifo_addr_n  [DEPTH];
  logic [1:0]  fifo_fault_n [DEPTH];
  logic        placed;

  // count only depends on registered state, so resp_ready never reaches req_ready
  assign req_ready   = !reset && !flush && (count < CNT_W'(DEPTH));
  assign accept      = req_valid && req_ready;
  assign mem_read    = accept && (req_fault == FAULT_OK);
  assign mem_address = req_address[TEXT_BITS-1:2];

  // Fault classification; misalignment wins over range
  always_comb begin
    req_fault = FAULT_OK;
    if (req_address[1:0] != 2'b00) begin
      req_fault = FAULT_MISALIGN;
    end else if ((req_address < TEXT_BEGIN) || (req_address > TEXT_END)) begin
      req_fault = FAULT_RANGE;
    end
  end

  // Pipeline valid bits
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int k = 0; k < int'(READ_LATENCY); k++) pipe_valid[k] <= 1'b0;
    end else begin
      pipe_valid[0] <= accept;
      for (int k = 1; k < int'(READ_LATENCY); k++) pipe_valid[k] <= pipe_valid[k-1];
    end
  end

  // Pipeline payload; qualified by the valid bits, so no reset needed
  always_ff @(posedge clock) begin
    pipe_fault[0] <= req_fault;
    pipe_addr[0]  <= req_address;
    for (int k = 1; k < int'(READ_LATENCY); k++) begin
      pipe_fault[k] <= pipe_fault[k-1];
      pipe_addr[k]  <= pipe_addr[k-1];
    end
  end

  assign push      = pipe_valid[READ_LATENCY-1];
  assign push_data = (pipe_fault[READ_LATENCY-1] == FAULT_OK) ? mem_read_data : 32'h0;
  assign pop       = fifo_valid[0] && resp_ready;

  // FIFO next state: shift on pop, then drop the new entry into the first free slot
  always_comb begin
    placed = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fifo_valid_n[i] = fifo_valid[i];
      fifo_data_n[i]  = fifo_data[i];
      fifo_addr_n[i]  = fifo_addr[i];
      fifo_fault_n[i] = fifo_fault[i];
    end
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_valid_n[i] = fifo_valid[i+1];
        fifo_data_n[i]  = fifo_data[i+1];
        fifo_addr_n[i]  = fifo_addr[i+1];
        fifo_fault_n[i] = fifo_fault[i+1];
      end
      fifo_valid_n[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!placed && !fifo_valid_n[i]) begin
          fifo_valid_n[i] = 1'b1;
          fifo_data_n[i]  = push_data;
          fifo_addr_n[i]  = pipe_addr[READ_LATENCY-1];
          fifo_fault_n[i] = pipe_fault[READ_LATENCY-1];
          placed          = 1'b1;
        end
      end
    end
  end

  // FIFO and occupancy registers; a pop during flush is void
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_valid[i] <= 1'b0;
        fifo_data[i]  <= 32'h0;
        fifo_addr[i]  <= 32'h0;
        fifo_fault[i] <= FAULT_OK;
      end
    end else if (flush) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_valid[i] <= 1'b0;
    end else begin
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_valid[i] <= fifo_valid_n[i];
        fifo_data[i]  <= fifo_data_n[i];
        fifo_addr[i]  <= fifo_addr_n[i];
        fifo_fault[i] <= fifo_fault_n[i];
      end
    end
  end

  assign resp_valid   = fifo_valid[0];
  assign resp_data    = fifo_data[0];
  assign resp_address = fifo_addr[0];
  assign resp_fault   = fifo_fault[0];

endmodule

// File: doc/text_memory_fetch_bus.md
# text_memory_fetch_bus

Parametrised instruction-fetch bus between the core's fetch stage and the program text memory. It adds a valid/ready request and response handshake, supports a configurable read latency for the synchronous text RAM, and buffers responses so that back-pressure never loses data. It also checks address range and alignment and reports faults in-band, and supports a flush that discards all in-flight fetches after a redirect.

## Interface
- TEXT_BEGIN, 32'h0040_0000: base byte address of the text segment; must be aligned to 2^TEXT_BITS.
- TEXT_BITS, 16: log2 of the text segment size in bytes. TEXT_END = TEXT_BEGIN + 2^TEXT_BITS − 1.
- READ_LATENCY, 1: text RAM read latency in clock edges; legal range 1–3.
- DEPTH, READ_LATENCY+2: derived, not overridable. Response FIFO entries and the outstanding-fetch limit.

Ports (clock and reset first):
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards all in-flight and buffered fetches.
- req_valid  in  1  fetch request present.
- req_address  in  32  fetch byte address.
- req_ready  out  1  request accepted at this edge if req_valid is also high.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response at this edge.
- resp_data  out  32  instruction word; 0 on fault.
- resp_address  out  32  address of the request that produced this response.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- mem_address  out  TEXT_BITS-2  word address to the text RAM.
- mem_read  out  1  RAM read enable.
- mem_read_data  in  32  RAM data, valid READ_LATENCY edges after the mem_read edge.

## Operation
- Accept condition: req_valid && req_ready. req_ready = !reset && !flush && (count < DEPTH).
  - count is a register: tracked pipeline entries plus FIFO entries.
  - resp_ready does not feed req_ready combinationally.
- Fault classification at acceptance:
  - req_address[1:0] != 0 → misaligned (01). Misaligned takes precedence over out of range.
  - Otherwise, address outside [TEXT_BEGIN, TEXT_END] → out of range (10).
  - The range check uses full 32-bit unsigned compares. Addresses at exactly TEXT_BEGIN and TEXT_END−3 are in range.
- Memory access:
  - mem_read = accept && no fault (combinational).
  - mem_address = req_address[TEXT_BITS-1:2].
  - Faulted requests issue no RAM read.
- Tracking pipeline: READ_LATENCY stages carrying {valid, fault, address}. A stage is loaded on accept and shifts every cycle.
- FIFO write:
  - When the tail stage is valid, the FIFO is written with {mem_read_data, or 0 if faulted; fault; address}.
  - Tail data with valid=0 is ignored.
- Ordering: responses leave strictly in acceptance order. Faulted responses take the same latency as good ones.
- FIFO outputs: resp_valid is high when the FIFO is non-empty. resp_* show the head entry and hold stable while resp_valid && !resp_ready.
- count update: +1 on accept, −1 on pop; simultaneous accept and pop leaves it unchanged. The FIFO cannot overflow, because count ≤ DEPTH bounds the total.
- Flush (flush high at an edge):
  - Clears all pipeline valid bits, empties the FIFO, and sets count to 0.
  - A resp pop in the same cycle is void.
  - RAM data already in flight arrives against invalid stages and is dropped.
- Reset (high at an edge):
  - Same clearing as flush, plus resp_data/resp_address/resp_fault registers go to 0.
  - Reset asserted mid-operation drops everything; there is no partial response.

## Timing
- Reset values: resp_valid 0, resp_data 0, resp_address 0, resp_fault 00, mem_read 0. req_ready is 0 while reset is high and 1 in the first cycle after.
- Latency: a request accepted at edge t produces resp_valid high in the cycle after edge t+READ_LATENCY, i.e. READ_LATENCY+1 cycles.
- Throughput: one fetch per cycle sustained while resp_ready is held high.
- Back-pressure: with resp_ready low, exactly DEPTH requests are accepted, then req_ready falls.
  - One pop raises req_ready in the following cycle.
- The RAM sees mem_address/mem_read in the accept cycle and returns data exactly READ_LATENCY edges later. There is no wait state on the RAM side.

## Test plan
- Single fetch, READ_LATENCY=1:
  - Stimulus: request 0x0040_0010, with RAM word 0x0000_0013 at that address.
  - Required: resp_valid two cycles after acceptance, resp_data 0x0000_0013, fault 00.
- Streaming:
  - Stimulus: 16 back-to-back sequential fetches from TEXT_BEGIN with resp_ready=1, at READ_LATENCY 1, 2 and 3.
  - Required: req_ready never drops, responses arrive in order with addresses +4 each.
- Faults:
  - Stimulus: 0x0040_0002, then 0x003F_FFFC, then TEXT_END+1.
  - Required: fault 01, 10, 10 respectively; mem_read never asserted; resp_data 0; order preserved relative to interleaved good fetches.
- Back-pressure:
  - Stimulus: resp_ready=0 with continuous requests.
  - Required: exactly READ_LATENCY+2 accepted; outputs stable; draining returns all of them intact and in order.
- Flush:
  - Stimulus: flush asserted while READ_LATENCY=3 has 3 fetches in flight and 2 buffered.
  - Required: resp_valid 0 next cycle, no stale response ever appears, and the next fetch returns after normal latency.
- Reset mid-stream:
  - Stimulus: reset for one cycle during streaming.
  - Required: all outputs at reset values, count 0, correct operation resumes after.
